alu_serial_seq: RTL
===================

# alu_serial_seq

Bit-serial 16-bit execution unit for the CPU datapath. It accepts a command and two operand words, then drives one `alu_1bit` slice for W consecutive cycles, LSB first. The slice's carry-out is registered back into its carry-in between bits, and the result is assembled in a shift register. It sits between the register-read stage, which supplies operands and command, and write-back, which consumes the result and flags through a valid/ready handshake.

## Interface
- `W`: default 16. Operand and result width. Must be ≥ 2.
- `clk`: input, 1 bit. Single clock; all state updates on its rising edge.
- `rst_n`: input, 1 bit. Reset, asynchronous and active-low.
- `in_valid`: input, 1 bit. Command, `a` and `b` are valid.
- `in_ready`: output, 1 bit. High only in IDLE.
- `cmd`: input, 3 bits. 0 AND, 1 OR, 2 XOR, 3 ADD, 4 SUB, 5 NOR, 6 NAND, 7 reserved.
- `a`, `b`: input, W bits. Operands.
- `out_valid`: output, 1 bit. `result` and flags are valid.
- `out_ready`: input, 1 bit. Downstream accepts the result.
- `result`: output, W bits. Computed word.
- `flag_z`, `flag_n`, `flag_c`, `flag_v`: output, 1 bit each. Zero, negative (`result[W-1]`), carry-out, signed overflow.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: `in_ready`=1. On `in_valid`&&`in_ready`, latch `a`, `b` and `cmd` into the shift registers, clear the bit counter, and go to RUN.
- Decode from `cmd` to the slice controls (`op`, `ainvert`, `bnegate`, initial carry):
  - AND: 000/0/0/0
  - OR: 010/0/0/0
  - XOR: 110/0/0/0
  - ADD: 100/0/0/0
  - SUB: 100/0/1/1
  - NOR: 000/1/1/0
  - NAND: 010/1/1/0
- Reserved `cmd`=7 runs the full sequence with the slice forced to AND and both operands forced to 0. The result is 0, with Z=1 and C=V=0.
- RUN, each cycle:
  - The slice sees `a_sh[0]`, `b_sh[0]` and `carry_q`.
  - `a_sh` and `b_sh` shift right.
  - `res_sh` <= {slice result, `res_sh[W-1:1]`}.
  - `carry_q` <= slice `cout`.
  - The counter increments. After the bit W-1 edge, go to DONE.
- The carry chain is arithmetic only. For logic commands, `carry_q` is still updated but `flag_c` and `flag_v` are forced to 0.
- Flags latch at the final RUN edge:
  - `flag_c`: cout of bit W-1.
  - `flag_v`: carry-in of bit W-1 XOR cout of bit W-1.
  - `flag_z`: final result == 0.
  - `flag_n`: MSB of the final result.
- DONE: `out_valid`=1. `result` and flags hold stable until `out_valid`&&`out_ready`, then go to IDLE.
- `in_valid` during RUN or DONE is ignored. No queueing, no overlap.
- Reset (asynchronous, any state) returns to IDLE and zeroes `result`, all flags, `out_valid`, the shift registers, the counter and `carry_q`. `in_ready` is 1 while `rst_n` is high and the state is IDLE. An in-flight operation is discarded and no `out_valid` follows.

## Timing
- Accept at edge k. Bits 0..W-1 are computed at edges k+1..k+W. `out_valid` is high from edge k+W, which gives a latency of W cycles (16 by default).
- The earliest next accept is at edge k+W+2: the handshake at edge k+W+1 returns the block to IDLE, and `in_ready` rises after that edge.
- With `out_ready` held high, throughput is one operation per W+2 cycles.
- `result` updates only at the final RUN edge. It is not a live shift view, and it holds its value in IDLE until the next completion.

## Structure
- Shared package `alu_pkg` holds:
  - `cmd` encoding constants (`CMD_AND`…`CMD_NAND`, `CMD_RSVD`).
  - Slice op constants `OP_AND`=3'b000, `OP_OR`=3'b010, `OP_XOR`=3'b110, `OP_ADD`=3'b100.
  - The state enum.
- The existing `alu_1bit` sub-module is instantiated exactly once, with all bit arithmetic going through it.
- The counter is $clog2(W) bits wide. The decode is a small combinational function in the package.

## Test plan
- AND: `a`=0x00FF, `b`=0x0F0F → `result`=0x000F, Z=0, N=0, C=0, V=0, with `out_valid` exactly 16 cycles after accept.
- ADD overflow: 0x7FFF + 0x0001 → 0x8000, N=1, V=1, C=0, Z=0. Also 0xFFFF + 0x0001 → 0x0000, Z=1, C=1, V=0.
- SUB: 0x0005 − 0x0005 → 0x0000, Z=1, C=1. Also 0x0003 − 0x0005 → 0xFFFE, N=1, C=0.
- NOR and NAND: `a`=0xF0F0, `b`=0xFF00 → NOR 0x000F, NAND 0x0FFF. XOR on the same operands → 0x0FF0.
- Backpressure: hold `out_ready`=0 for 10 cycles in DONE. `result` and flags stay stable, `in_ready`=0, and a pulsed `in_valid` is ignored. Release `out_ready` and the next accept happens no earlier than 2 cycles later.
- Reset mid-RUN: deassert `rst_n` at bit 7, asynchronously between edges. All outputs go to 0 immediately, `out_valid` never asserts for the aborted operation, and a fresh ADD 1+2 after reset returns 0x0003.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the bit-serial ALU: command codes, slice op codes,
// sequencer states and the command-to-slice-control decode.
package alu_pkg;

    localparam logic [2:0] CMD_AND  = 3'd0;
    localparam logic [2:0] CMD_OR   = 3'd1;
    localparam logic [2:0] CMD_XOR  = 3'd2;
    localparam logic [2:0] CMD_ADD  = 3'd3;
    localparam logic [2:0] CMD_SUB  = 3'd4;
    localparam logic [2:0] CMD_NOR  = 3'd5;
    localparam logic [2:0] CMD_NAND = 3'd6;
    localparam logic [2:0] CMD_RSVD = 3'd7;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b110;
    localparam logic [2:0] OP_ADD = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic [2:0] op;
        logic       ainvert;
        logic       bnegate;
        logic       cin;
        logic       arith;     // carry/overflow flags are meaningful
        logic       zero_ops;  // reserved command: operands forced to 0
    } slice_ctrl_t;

    function automatic slice_ctrl_t decode_cmd(input logic [2:0] cmd);
        slice_ctrl_t c;
        c = '{op: OP_AND, ainvert: 1'b0, bnegate: 1'b0, cin: 1'b0,
              arith: 1'b0, zero_ops: 1'b0};
        case (cmd)
            CMD_AND:  c.op = OP_AND;
            CMD_OR:   c.op = OP_OR;
            CMD_XOR:  c.op = OP_XOR;
            CMD_ADD:  begin c.op = OP_ADD; c.arith = 1'b1; end
            CMD_SUB:  begin c.op = OP_ADD; c.bnegate = 1'b1; c.cin = 1'b1; c.arith = 1'b1; end
            CMD_NOR:  begin c.op = OP_AND; c.ainvert = 1'b1; c.bnegate = 1'b1; end
            CMD_NAND: begin c.op = OP_OR;  c.ainvert = 1'b1; c.bnegate = 1'b1; end
            default:  c.zero_ops = 1'b1;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/alu_1bit.sv
// One-bit ALU slice with optional operand inversion; carry-out is always the
// full-adder carry of the (possibly inverted) operands.
module alu_1bit
    import alu_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic       cin,
    input  logic       ainvert,
    input  logic       bnegate,
    input  logic [2:0] op,
    output logic       result,
    output logic       cout
);

    logic aa;
    logic bb;

    assign aa   = a ^ ainvert;
    assign bb   = b ^ bnegate;
    assign cout = (aa & bb) | (aa & cin) | (bb & cin);

    always_comb begin
        case (op)
            OP_OR:   result = aa | bb;
            OP_XOR:  result = aa ^ bb;
            OP_ADD:  result = aa ^ bb ^ cin;
            default: result = aa & bb;
        endcase
    end

endmodule

// File: rtl/alu_serial_seq.sv
// Bit-serial W-bit execution unit: drives one alu_1bit slice LSB first for W
// cycles, then presents the result and flags through a valid/ready handshake.
module alu_serial_seq
    import alu_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [2:0]   cmd,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic         flag_z,
    output logic         flag_n,
    output logic         flag_c,
    output logic         flag_v
);

    localparam int CNT_W = $clog2(W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(W - 1);

    state_e           state_q, state_d;
    slice_ctrl_t      ctrl_q, ctrl_d;
    logic [W-1:0]     a_sh_q, a_sh_d;
    logic [W-1:0]     b_sh_q, b_sh_d;
    logic [W-2:0]     res_sh_q, res_sh_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W-1:0]     result_q, result_d;
    logic             flag_z_q, flag_z_d;
    logic             flag_n_q, flag_n_d;
    logic             flag_c_q, flag_c_d;
    logic             flag_v_q, flag_v_d;
    logic             out_valid_q, out_valid_d;

    logic             slice_res;
    logic             slice_cout;
    logic [W-1:0]     final_word;

    alu_1bit u_slice (
        .a       (a_sh_q[0]),
        .b       (b_sh_q[0]),
        .cin     (carry_q),
        .ainvert (ctrl_q.ainvert),
        .bnegate (ctrl_q.bnegate),
        .op      (ctrl_q.op),
        .result  (slice_res),
        .cout    (slice_cout)
    );

    // The last bit bypasses the shift register, so only W-1 bits are stored.
    assign final_word = {slice_res, res_sh_q};
    assign in_ready   = rst_n && (state_q == ST_IDLE);

    always_comb begin
        // NOTE: every *_d defaults to its flop so no path infers a latch.
        state_d     = state_q;
        ctrl_d      = ctrl_q;
        a_sh_d      = a_sh_q;
        b_sh_d      = b_sh_q;
        res_sh_d    = res_sh_q;
        carry_d     = carry_q;
        cnt_d       = cnt_q;
        result_d    = result_q;
        flag_z_d    = flag_z_q;
        flag_n_d    = flag_n_q;
        flag_c_d    = flag_c_q;
        flag_v_d    = flag_v_q;
        out_valid_d = out_valid_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready) begin
                    ctrl_d  = decode_cmd(cmd);
                    a_sh_d  = ctrl_d.zero_ops ? '0 : a;
                    b_sh_d  = ctrl_d.zero_ops ? '0 : b;
                    carry_d = ctrl_d.cin;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                res_sh_d = final_word[W-1:1];
                carry_d  = slice_cout;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_BIT) begin
                    result_d    = final_word;
                    flag_z_d    = (final_word == '0);
                    flag_n_d    = slice_res;
                    flag_c_d    = ctrl_q.arith & slice_cout;
                    flag_v_d    = ctrl_q.arith & (carry_q ^ slice_cout);
                    out_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ctrl_q      <= '0;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            res_sh_q    <= '0;
            carry_q     <= 1'b0;
            cnt_q       <= '0;
            result_q    <= '0;
            flag_z_q    <= 1'b0;
            flag_n_q    <= 1'b0;
            flag_c_q    <= 1'b0;
            flag_v_q    <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ctrl_q      <= ctrl_d;
            a_sh_q      <= a_sh_d;
            b_sh_q      <= b_sh_d;
            res_sh_q    <= res_sh_d;
            carry_q     <= carry_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            flag_z_q    <= flag_z_d;
            flag_n_q    <= flag_n_d;
            flag_c_q    <= flag_c_d;
            flag_v_q    <= flag_v_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign flag_z    = flag_z_q;
    assign flag_n    = flag_n_q;
    assign flag_c    = flag_c_q;
    assign flag_v    = flag_v_q;

endmodule
